// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pkg                                                          |
// | Shared state encodings and default widths for the fetch stage.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package fetch_pkg;

  localparam logic [1:0] FETCH_BOOT  = 2'd0;
  localparam logic [1:0] FETCH_RUN   = 2'd1;
  localparam logic [1:0] FETCH_FLUSH = 2'd2;

  localparam int DEF_PC_W     = 16;
  localparam int DEF_INSTR_W  = 16;
  localparam int DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    ST_BOOT  = FETCH_BOOT,
    ST_RUN   = FETCH_RUN,
    ST_FLUSH = FETCH_FLUSH
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_fifo                                                         |
// | DEPTH-entry prefetch FIFO with synchronous flush and occupancy.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = pop & ~w_empty;
  // A pop frees the slot the same cycle, so full+pop+push is accepted.
  assign w_do_push = push & ~flush & (~w_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head_data = r_mem[r_rd_ptr];
  assign occupancy = r_count;
  assign empty     = w_empty;

endmodule
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | inst_fetch_queue                                                   |
// | Sequential PC fetch with credit-based prefetch FIFO and redirect.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          PC_W     = DEF_PC_W,
  parameter int          INSTR_W  = DEF_INSTR_W,
  parameter int          DEPTH    = 4,
  parameter int unsigned PC_STEP  = 1,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  output logic                     imem_en,
  output logic [PC_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]       imem_rdata,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [PC_W-1:0]          dec_pc,
  output logic [INSTR_W-1:0]       dec_instr,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = PC_W + INSTR_W;

  fetch_state_e     r_state;
  logic [PC_W-1:0]  r_fetch_pc;
  logic             r_inflight;
  logic [PC_W-1:0]  r_inflight_pc;

  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic             w_empty;
  logic [CNT_W:0]   w_committed;
  logic [ENT_W-1:0] w_head;
  logic [CNT_W-1:0] w_occ;

  assign w_pop  = dec_valid & dec_ready;
  assign w_push = r_inflight & ~redirect;

  // Entries held plus the one landing next cycle, less the one leaving now.
  assign w_committed = {1'b0, w_occ} + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);
  assign w_issue     = (r_state == ST_RUN) & ~redirect & (w_committed < (CNT_W+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_BOOT;
      r_fetch_pc    <= PC_W'(RESET_PC);
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_fetch_pc;
      if (redirect) begin
        r_state    <= ST_FLUSH;
        r_fetch_pc <= redirect_pc;
      end else begin
        case (r_state)
          ST_BOOT:  r_state <= ST_RUN;
          ST_FLUSH: r_state <= ST_RUN;
          ST_RUN:   r_state <= ST_RUN;
          default:  r_state <= ST_BOOT;
        endcase
        if (w_issue) r_fetch_pc <= r_fetch_pc + PC_W'(PC_STEP);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (w_push),
    .push_data ({r_inflight_pc, imem_rdata}),
    .pop       (w_pop),
    .head_data (w_head),
    .occupancy (w_occ),
    .empty     (w_empty)
  );

  assign imem_en   = w_issue;
  assign imem_addr = r_fetch_pc;
  assign dec_valid = ~w_empty;
  assign dec_pc    = dec_valid ? w_head[ENT_W-1:INSTR_W] : '0;
  assign dec_instr = dec_valid ? w_head[INSTR_W-1:0]     : '0;
  assign occupancy = w_occ;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_inst_fetch_queue                                                |
// | Random + directed stimulus against a queue-based fetch model.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [15:0] dec_pc;
  logic [15:0] dec_instr;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_errors = 0;

  inst_fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_pc      (dec_pc),
    .dec_instr   (dec_instr),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] instr_of(input logic [15:0] a);
    return {a[3:0], a[15:4]} ^ 16'hC3A5;
  endfunction

  // Instruction memory: one-cycle latency, garbage when not read.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= instr_of(imem_addr);
    else         imem_rdata <= 16'($urandom);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: decode-side queue of PCs plus the one response in flight.
  logic [15:0] m_fifo[$];
  bit          m_live  = 0;
  bit          m_pend  = 0;
  logic [15:0] m_pend_pc;
  logic [15:0] m_pc;
  int          m_quiet = 0;

  always @(negedge clk) begin
    bit m_pop;
    bit m_issue;
    m_pop   = (m_fifo.size() > 0) && dec_ready;
    m_issue = (m_quiet == 0) && !redirect &&
              ((m_fifo.size() + int'(m_pend) - int'(m_pop)) < DEPTH);
    if (m_live) begin
      check("m_occupancy", 32'(occupancy), 32'(m_fifo.size()));
      check("m_dec_valid", 32'(dec_valid), 32'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) begin
        check("m_dec_pc", 32'(dec_pc), 32'(m_fifo[0]));
        check("m_dec_instr", 32'(dec_instr), 32'(instr_of(m_fifo[0])));
      end else begin
        check("m_empty_pc", 32'(dec_pc), 32'h0);
      end
      check("m_imem_en", 32'(imem_en), 32'(m_issue));
      if (m_issue) check("m_imem_addr", 32'(imem_addr), 32'(m_pc));
    end
    if (!rst) begin
      m_fifo.delete();
      m_pend  = 0;
      m_pc    = 16'h0000;
      m_quiet = 1;
      m_live  = 1;
    end else begin
      if (m_pop) void'(m_fifo.pop_front());
      if (redirect) begin
        m_fifo.delete();
        m_pend  = 0;
        m_pc    = redirect_pc;
        m_quiet = 1;
      end else begin
        if (m_pend) m_fifo.push_back(m_pend_pc);
        m_pend = m_issue;
        if (m_issue) begin
          m_pend_pc = m_pc;
          m_pc      = m_pc + 16'd1;
        end
        if (m_quiet > 0) m_quiet--;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && !dec_valid; i++) @(negedge clk);
    check(name, 32'(dec_valid), 32'h1);
  endtask

  logic [15:0] wrap_exp [4];

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
    wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF;
    wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0001;

    // Reset, then free-run
    next_cycle(); next_cycle();
    @(negedge clk);
    check("rst_occupancy", 32'(occupancy), 32'h0);
    check("rst_dec_valid", 32'(dec_valid), 32'h0);
    check("rst_imem_en", 32'(imem_en), 32'h0);
    check("rst_dec_pc", 32'(dec_pc), 32'h0);
    next_cycle(); rst = 1'b1;
    @(negedge clk); check("boot_no_issue", 32'(imem_en), 32'h0);
    next_cycle(); @(negedge clk);
    check("first_issue", 32'(imem_en), 32'h1);
    check("first_addr", 32'(imem_addr), 32'h0);
    next_cycle(); @(negedge clk);
    check("second_addr", 32'(imem_addr), 32'h1);
    check("not_yet_valid", 32'(dec_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); @(negedge clk);
      check("stream_pc", 32'(dec_pc), 32'(i));
      check("stream_instr", 32'(dec_instr), 32'(instr_of(16'(i))));
    end

    // Backpressure from reset
    next_cycle(); rst = 1'b0; dec_ready = 1'b0;
    next_cycle(); rst = 1'b1;
    repeat (12) next_cycle();
    @(negedge clk);
    check("bp_occupancy", 32'(occupancy), 32'h4);
    check("bp_no_issue", 32'(imem_en), 32'h0);
    check("bp_head_pc", 32'(dec_pc), 32'h0);

    // Redirect with 3 entries buffered and 1 in flight
    next_cycle(); dec_ready = 1'b1;
    next_cycle(); dec_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    check("rd_pre_occupancy", 32'(occupancy), 32'h3);
    check("rd_suppress", 32'(imem_en), 32'h0);
    next_cycle(); redirect = 1'b0; dec_ready = 1'b1;
    @(negedge clk);
    check("rd_flushed", 32'(dec_valid), 32'h0);
    check("rd_flush_no_issue", 32'(imem_en), 32'h0);
    next_cycle(); @(negedge clk);
    check("rd_issue_addr", 32'(imem_addr), 32'h0040);
    wait_valid("rd_valid_timeout", 8);
    check("rd_first_pc", 32'(dec_pc), 32'h0040);

    // Back-to-back redirects
    next_cycle(); redirect = 1'b1; redirect_pc = 16'h0100;
    next_cycle(); redirect_pc = 16'h0200;
    next_cycle(); redirect = 1'b0;
    wait_valid("b2b_valid_timeout", 8);
    check("b2b_first_pc", 32'(dec_pc), 32'h0200);

    // PC wrap
    next_cycle(); redirect = 1'b1; redirect_pc = 16'hFFFE;
    next_cycle(); redirect = 1'b0;
    wait_valid("wrap_valid_timeout", 8);
    for (int i = 0; i < 4; i++) begin
      check("wrap_pc", 32'(dec_pc), 32'(wrap_exp[i]));
      next_cycle(); @(negedge clk);
    end

    // Reset with a full FIFO
    next_cycle(); dec_ready = 1'b0;
    repeat (10) next_cycle();
    rst = 1'b0;
    next_cycle(); rst = 1'b1;
    @(negedge clk);
    check("mid_rst_occupancy", 32'(occupancy), 32'h0);
    check("mid_rst_valid", 32'(dec_valid), 32'h0);
    check("mid_rst_imem_en", 32'(imem_en), 32'h0);
    check("mid_rst_addr", 32'(imem_addr), 32'h0);
    check("mid_rst_pc", 32'(dec_pc), 32'h0);
    check("mid_rst_instr", 32'(dec_instr), 32'h0);
    next_cycle(); @(negedge clk);
    check("mid_rst_restart", 32'(imem_en), 32'h1);
    check("mid_rst_restart_addr", 32'(imem_addr), 32'h0);

    // Randomised traffic with varying backpressure bias
    for (int blk = 0; blk < 15; blk++) begin
      int bias;
      bias = $urandom_range(0, 3);
      for (int c = 0; c < 200; c++) begin
        next_cycle();
        dec_ready   = ($urandom_range(0, 3) < bias + 1);
        redirect    = ($urandom_range(0, 24) == 0);
        redirect_pc = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                                  : 16'hFFF0 + 16'($urandom_range(0, 15));
        rst         = ($urandom_range(0, 299) != 0);
      end
    end
    next_cycle();
    rst = 1'b1; redirect = 1'b0; dec_ready = 1'b1;
    repeat (5) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
